// File: rtl/cpu_pkg.sv
// Shared constants and encodings for the data-memory port arbiter.
package cpu_pkg;

    localparam int NUM_PORTS  = 2;
    localparam int DEFAULT_AW = 30;
    localparam int DEFAULT_DW = 32;

    // Identifies which requester owns an outstanding load response.
    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } owner_e;

endpackage

// File: rtl/rr_arb2.sv
// Two-way arbiter: combinational grant, 1-bit last-granted pointer.
// RR != 0 alternates on ties; RR == 0 always favours port 0.
module rr_arb2
    import cpu_pkg::*;
#(
    parameter int RR = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic [NUM_PORTS-1:0] i_req,
    output logic [NUM_PORTS-1:0] o_gnt
);

    // Port granted most recently; reset to PORT1 so port 0 wins the first tie.
    owner_e last_q;

    // Grant decision from the current requests and the pointer.
    always_comb begin
        // NOTE: default every comb output first so no path leaves it unassigned (no latch).
        o_gnt = '0;
        if (!i_rst) begin
            unique case (i_req)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = ((RR != 0) && (last_q == PORT0)) ? 2'b10 : 2'b01;
                default: o_gnt = '0;
            endcase
        end
    end

    // Pointer moves only when a request is actually accepted.
    always_ff @(posedge i_clk) begin
        // NOTE: state registers use non-blocking assignments so all flops update together.
        if (i_rst) begin
            last_q <= PORT1;
        end else if (|o_gnt) begin
            last_q <= o_gnt[1] ? PORT1 : PORT0;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-cycle-latency data memory between two requesters.
// Routes the granted request to memory and steers the read response back
// to the port that issued the load, one access per cycle.
module dmem_arbiter
    import cpu_pkg::*;
#(
    parameter int AW = DEFAULT_AW,
    parameter int DW = DEFAULT_DW,
    parameter int RR = 1
) (
    input  logic            i_clk,
    input  logic            i_rst,

    input  logic            i_req_0,
    output logic            o_gnt_0,
    input  logic [AW-1:0]   i_addr_0,
    input  logic [DW-1:0]   i_wr_data_0,
    input  logic [DW/8-1:0] i_mask_0,
    input  logic            i_we_0,
    output logic            o_rvalid_0,
    output logic [DW-1:0]   o_rd_data_0,

    input  logic            i_req_1,
    output logic            o_gnt_1,
    input  logic [AW-1:0]   i_addr_1,
    input  logic [DW-1:0]   i_wr_data_1,
    input  logic [DW/8-1:0] i_mask_1,
    input  logic            i_we_1,
    output logic            o_rvalid_1,
    output logic [DW-1:0]   o_rd_data_1,

    output logic            o_mem_en,
    output logic [AW-1:0]   o_mem_addr,
    output logic [DW-1:0]   o_mem_wr_data,
    output logic [DW/8-1:0] o_mem_mask,
    output logic            o_mem_we,
    input  logic [DW-1:0]   i_mem_rd_data
);

    logic [NUM_PORTS-1:0] req;
    logic [NUM_PORTS-1:0] gnt;
    logic                 granted;
    logic                 sel_we;
    owner_e               owner_q;
    logic                 pend_q;

    assign req = {i_req_1, i_req_0};

    rr_arb2 #(
        .RR (RR)
    ) u_arb (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_req (req),
        .o_gnt (gnt)
    );

    assign o_gnt_0 = gnt[0];
    assign o_gnt_1 = gnt[1];
    assign granted = |gnt;
    assign sel_we  = gnt[1] ? i_we_1 : i_we_0;

    // Route the winning port's request onto the memory interface.
    always_comb begin
        o_mem_en      = granted;
        o_mem_addr    = gnt[1] ? i_addr_1    : i_addr_0;
        o_mem_wr_data = gnt[1] ? i_wr_data_1 : i_wr_data_0;
        o_mem_mask    = '0;
        o_mem_we      = 1'b0;
        if (granted) begin
            o_mem_mask = gnt[1] ? i_mask_1 : i_mask_0;
            o_mem_we   = sel_we;
        end
    end

    // Remember who issued an accepted load so the next-cycle data goes back to it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            pend_q  <= 1'b0;
            owner_q <= PORT0;
        end else begin
            pend_q <= granted && !sel_we;
            if (granted) begin
                owner_q <= gnt[1] ? PORT1 : PORT0;
            end
        end
    end

    // Reset is synchronous, so a load accepted just before reset still has
    // pend_q set during the reset cycle; masking with i_rst suppresses it.
    assign o_rvalid_0 = pend_q && !i_rst && (owner_q == PORT0);
    assign o_rvalid_1 = pend_q && !i_rst && (owner_q == PORT1);

    // Memory read data is already aligned with rvalid; no extra storage.
    assign o_rd_data_0 = i_mem_rd_data;
    assign o_rd_data_1 = i_mem_rd_data;

endmodule
